// File: rtl/bcd_conv_pkg.sv
// rtl/bcd_conv_pkg.sv - shared types and helpers for the time-shared BCD conversion scheduler
package bcd_conv_pkg;

    localparam int N_FIELDS = 6;

    typedef enum logic [2:0] {
        F_SS,
        F_MM,
        F_HH,
        F_DD,
        F_MO,
        F_YYYY
    } field_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_COMMIT
    } state_e;

    function automatic logic [3:0] add3_nibble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/dd_engine.sv
// rtl/dd_engine.sv - iterative double-dabble datapath, one shift per enabled cycle, four BCD digits
module dd_engine
    import bcd_conv_pkg::*;
#(
    parameter int ENG_W = 16
) (
    input  logic             clk,
    input  logic             load,
    input  logic             shift_en,
    input  logic [ENG_W-1:0] bin_in,
    output logic [15:0]      bcd_out
);

    logic [16+ENG_W-1:0] eng_q;
    logic [16+ENG_W-1:0] eng_adj;

    always_comb begin
        eng_adj = eng_q;
        for (int i = 0; i < 4; i++) begin
            eng_adj[ENG_W+4*i +: 4] = add3_nibble(eng_q[ENG_W+4*i +: 4]);
        end
    end

    // No reset: every conversion starts with a load that fully initialises the register.
    always_ff @(posedge clk) begin
        if (load) begin
            eng_q <= {16'h0000, bin_in};
        end else if (shift_en) begin
            eng_q <= eng_adj << 1;
        end
    end

    assign bcd_out = eng_q[ENG_W +: 16];

endmodule

// File: rtl/bcd_conv_scheduler.sv
// rtl/bcd_conv_scheduler.sv - snapshots six time fields, converts them serially, commits all BCD outputs at once
// Optional: define BCD_SKIP_UNCHANGED_EN to skip fields whose value matches the last one converted.
module bcd_conv_scheduler
    import bcd_conv_pkg::*;
#(
    parameter int ENG_W  = 16,
    parameter int YEAR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_req,
    input  logic [5:0]        sec_bin,
    input  logic [5:0]        min_bin,
    input  logic [4:0]        hour_bin,
    input  logic [4:0]        day_bin,
    input  logic [3:0]        month_bin,
    input  logic [YEAR_W-1:0] year_bin,
    output logic [7:0]        bcd_ss,
    output logic [7:0]        bcd_mm,
    output logic [7:0]        bcd_hh,
    output logic [7:0]        bcd_dd,
    output logic [7:0]        bcd_mo,
    output logic [15:0]       bcd_yyyy,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(ENG_W);

    state_e            state_q, state_d;
    field_e            field_q, field_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              done_q;
    logic              snap_en, eng_load, eng_shift, store_en, commit_en;
    logic              last_field;
    logic [ENG_W-1:0]  snap_q [N_FIELDS];
    logic [7:0]        sh_ss, sh_mm, sh_hh, sh_dd, sh_mo;
    logic [15:0]       sh_yyyy;
    logic [15:0]       eng_bcd;

`ifdef BCD_SKIP_UNCHANGED_EN
    logic [ENG_W-1:0]    last_q [N_FIELDS];
    logic [N_FIELDS-1:0] valid_q;
    logic                skip_hit;

    assign skip_hit = valid_q[field_q] && (last_q[field_q] == snap_q[field_q]);
`endif

    assign last_field = (field_q == F_YYYY);

    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | (conv_req && (state_q != S_IDLE));
        snap_en   = 1'b0;
        eng_load  = 1'b0;
        eng_shift = 1'b0;
        store_en  = 1'b0;
        commit_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (conv_req) begin
                    snap_en = 1'b1;
                    field_d = F_SS;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef BCD_SKIP_UNCHANGED_EN
                if (skip_hit) begin
                    if (last_field) begin
                        state_d = S_COMMIT;
                    end else begin
                        field_d = field_e'(field_q + 3'd1);
                    end
                end else begin
                    eng_load = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
`else
                eng_load = 1'b1;
                cnt_d    = '0;
                state_d  = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                eng_shift = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ENG_W-1)) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                store_en = 1'b1;
                if (last_field) begin
                    state_d = S_COMMIT;
                end else begin
                    field_d = field_e'(field_q + 3'd1);
                    state_d = S_LOAD;
                end
            end
            S_COMMIT: begin
                // A request seen in this very cycle restarts exactly like a held pending flag.
                commit_en = 1'b1;
                pending_d = 1'b0;
                if (pending_q || conv_req) begin
                    snap_en = 1'b1;
                    field_d = F_SS;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (snap_en) begin
            snap_q[F_SS]   <= ENG_W'(sec_bin);
            snap_q[F_MM]   <= ENG_W'(min_bin);
            snap_q[F_HH]   <= ENG_W'(hour_bin);
            snap_q[F_DD]   <= ENG_W'(day_bin);
            snap_q[F_MO]   <= ENG_W'(month_bin);
            snap_q[F_YYYY] <= ENG_W'(year_bin);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            field_q   <= F_SS;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            {sh_ss, sh_mm, sh_hh, sh_dd, sh_mo, sh_yyyy} <= '0;
            {bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo, bcd_yyyy} <= '0;
        end else begin
            state_q   <= state_d;
            field_q   <= field_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            done_q    <= commit_en;
            if (store_en) begin
                case (field_q)
                    F_SS:    sh_ss   <= eng_bcd[7:0];
                    F_MM:    sh_mm   <= eng_bcd[7:0];
                    F_HH:    sh_hh   <= eng_bcd[7:0];
                    F_DD:    sh_dd   <= eng_bcd[7:0];
                    F_MO:    sh_mo   <= eng_bcd[7:0];
                    F_YYYY:  sh_yyyy <= eng_bcd;
                    default: ;
                endcase
            end
            if (commit_en) begin
                bcd_ss   <= sh_ss;
                bcd_mm   <= sh_mm;
                bcd_hh   <= sh_hh;
                bcd_dd   <= sh_dd;
                bcd_mo   <= sh_mo;
                bcd_yyyy <= sh_yyyy;
            end
        end
    end

`ifdef BCD_SKIP_UNCHANGED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (store_en) begin
            last_q[field_q]  <= snap_q[field_q];
            valid_q[field_q] <= 1'b1;
        end
    end
`endif

    dd_engine #(.ENG_W(ENG_W)) u_engine (
        .clk      (clk),
        .load     (eng_load),
        .shift_en (eng_shift),
        .bin_in   (snap_q[field_q]),
        .bcd_out  (eng_bcd)
    );

    assign busy = (state_q != S_IDLE) || done_q;
    assign done = done_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb/tb_bcd_conv_scheduler.sv - self-checking bench for bcd_conv_scheduler
module tb_bcd_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        conv_req;
    logic [5:0]  sec_bin, min_bin;
    logic [4:0]  hour_bin, day_bin;
    logic [3:0]  month_bin;
    logic [11:0] year_bin;
    logic [7:0]  bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo;
    logic [15:0] bcd_yyyy;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;

    bcd_conv_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .conv_req  (conv_req),
        .sec_bin   (sec_bin),
        .min_bin   (min_bin),
        .hour_bin  (hour_bin),
        .day_bin   (day_bin),
        .month_bin (month_bin),
        .year_bin  (year_bin),
        .bcd_ss    (bcd_ss),
        .bcd_mm    (bcd_mm),
        .bcd_hh    (bcd_hh),
        .bcd_dd    (bcd_dd),
        .bcd_mo    (bcd_mo),
        .bcd_yyyy  (bcd_yyyy),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Reference model: a snapshot, a countdown to the commit edge and a pending flag.
    int          m_snap [6];
    int          m_last [6];
    bit          m_valid;
    int          cd;
    bit          m_pend;
    bit          m_done;
    bit          m_live = 1'b0;
    logic [15:0] m_out [6];

    function automatic void model_accept();
        int lat;
        m_snap[0] = int'(sec_bin);
        m_snap[1] = int'(min_bin);
        m_snap[2] = int'(hour_bin);
        m_snap[3] = int'(day_bin);
        m_snap[4] = int'(month_bin);
        m_snap[5] = int'(year_bin);
        lat = 2;
        for (int i = 0; i < 6; i++) begin
`ifdef BCD_SKIP_UNCHANGED_EN
            lat += (m_valid && m_last[i] == m_snap[i]) ? 1 : 18;
`else
            lat += 18;
`endif
            m_last[i] = m_snap[i];
        end
        m_valid = 1'b1;
        cd = lat - 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live  = 1'b1;
            cd      = 0;
            m_pend  = 1'b0;
            m_done  = 1'b0;
            m_valid = 1'b0;
            for (int i = 0; i < 6; i++) m_out[i] = '0;
        end else if (m_live) begin
            m_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    for (int i = 0; i < 6; i++) m_out[i] = to_bcd(m_snap[i]);
                    m_done = 1'b1;
                    if (m_pend || conv_req) model_accept();
                    m_pend = 1'b0;
                end else if (conv_req) begin
                    m_pend = 1'b1;
                end
            end else if (conv_req) begin
                model_accept();
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cmp_done", done, m_done);
            check("cmp_busy", busy, (cd > 0) || m_done);
            check("cmp_ss", bcd_ss, m_out[0][7:0]);
            check("cmp_mm", bcd_mm, m_out[1][7:0]);
            check("cmp_hh", bcd_hh, m_out[2][7:0]);
            check("cmp_dd", bcd_dd, m_out[3][7:0]);
            check("cmp_mo", bcd_mo, m_out[4][7:0]);
            check("cmp_yyyy", bcd_yyyy, m_out[5]);
        end
    end

    task automatic set_in(input int s, input int m, input int h, input int d, input int mo, input int y);
        sec_bin   = 6'(s);
        min_bin   = 6'(m);
        hour_bin  = 5'(h);
        day_bin   = 5'(d);
        month_bin = 4'(mo);
        year_bin  = 12'(y);
    endtask

    task automatic wait_done(output int lat);
        int gaps = 0;
        lat = 0;
        do begin
            @(negedge clk);
            conv_req = 1'b0;
            lat++;
            if (!busy) gaps++;
        end while (!done && lat < 400);
        check("done_seen", done, 1'b1);
        check("busy_gap", gaps, 0);
    endtask

    task automatic run(input int s, input int m, input int h, input int d, input int mo, input int y,
                       output int lat);
        set_in(s, m, h, d, mo, y);
        conv_req = 1'b1;
        wait_done(lat);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                              input logic [7:0] d, input logic [7:0] mo, input logic [15:0] y);
        check({tag, "_ss"}, bcd_ss, s);
        check({tag, "_mm"}, bcd_mm, m);
        check({tag, "_hh"}, bcd_hh, h);
        check({tag, "_dd"}, bcd_dd, d);
        check({tag, "_mo"}, bcd_mo, mo);
        check({tag, "_yyyy"}, bcd_yyyy, y);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat;
        int c;
        int extra;
        rst      = 1'b1;
        conv_req = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        expect_out("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic conversion with fixed latency
        run(59, 7, 23, 31, 12, 2024, lat);
        check("t1_latency", lat, 110);
        expect_out("t1", 8'h59, 8'h07, 8'h23, 8'h31, 8'h12, 16'h2024);
        @(negedge clk);

        // Inputs change after the snapshot
        set_in(45, 30, 12, 15, 6, 1999);
        conv_req = 1'b1;
        @(negedge clk);
        conv_req = 1'b0;
        repeat (4) @(negedge clk);
        set_in(1, 2, 3, 4, 5, 2000);
        wait_done(lat);
        check("t2_latency", lat + 5, 110);
        expect_out("t2", 8'h45, 8'h30, 8'h12, 8'h15, 8'h06, 16'h1999);
        @(negedge clk);

        // Two requests during a conversion merge into one extra conversion
        set_in(10, 20, 3, 4, 5, 2010);
        conv_req = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            conv_req = (c == 20 || c == 40);
            if (c == 50) set_in(11, 22, 13, 14, 9, 2011);
        end while (!done && c < 400);
        check("t3_first_latency", c, 110);
        expect_out("t3a", 8'h10, 8'h20, 8'h03, 8'h04, 8'h05, 16'h2010);
        set_in(33, 44, 5, 6, 7, 2033);
        wait_done(lat);
        check("t3_second_latency", lat, 109);
        expect_out("t3b", 8'h11, 8'h22, 8'h13, 8'h14, 8'h09, 16'h2011);
        count_dones(150, extra);
        check("t3_no_third_done", extra, 0);

        // Reset in the middle of a conversion
        set_in(1, 1, 1, 1, 1, 2001);
        conv_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            conv_req = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_out("t4_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
        check("t4_busy", busy, 1'b0);
        count_dones(150, extra);
        check("t4_no_done", extra, 0);
        run(1, 1, 1, 1, 1, 2001, lat);
        check("t4_latency", lat, 110);
        expect_out("t4", 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 16'h2001);
        @(negedge clk);

        // Boundaries
        run(63, 59, 23, 31, 12, 4095, lat);
        check("t5_latency", lat, 110);
        expect_out("t5max", 8'h63, 8'h59, 8'h23, 8'h31, 8'h12, 16'h4095);
        @(negedge clk);
        run(0, 0, 0, 0, 0, 0, lat);
        check("t5_zero_latency", lat, 110);
        expect_out("t5zero", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
        @(negedge clk);

`ifdef BCD_SKIP_UNCHANGED_EN
        run(0, 0, 0, 0, 0, 0, lat);
        check("t6_same_latency", lat, 8);
        expect_out("t6same", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
        @(negedge clk);
        run(0, 37, 0, 0, 0, 0, lat);
        check("t6_mm_latency", lat, 25);
        expect_out("t6mm", 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 16'h0000);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
